// File: rtl/muldiv_pkg.sv
// Shared constants and state encoding for the multiply/divide sequencer.
package muldiv_pkg;
  localparam int MD_ITERS = 32;
  localparam int CNT_W = $clog2(MD_ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_ITERS - 1);

  // opE bit positions: bit0 selects divide, bit1 selects signed handling
  localparam int OP_DIV_BIT = 0;
  localparam int OP_SGN_BIT = 1;

  localparam logic [31:0] DIVZERO_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } md_state_e;
endpackage

// File: rtl/muldiv_if.sv
// Execute-stage request/response bundle between the pipeline and the mult/div sequencer.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             startE;
  logic [1:0]       opE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             cancel;
  logic             mdreqD;
  logic             hlreadD;
  logic             stallmd;
  logic             busy;
  logic             hlwrite;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             divzero;

  modport master (
    output startE, opE, srcaE, srcbE, cancel, mdreqD, hlreadD,
    input  stallmd, busy, hlwrite, hi, lo, divzero
  );

  modport slave (
    input  startE, opE, srcaE, srcbE, cancel, mdreqD, hlreadD,
    output stallmd, busy, hlwrite, hi, lo, divzero
  );
endinterface

// File: rtl/muldiv_iter.sv
// One radix-2 step: shift-add multiply or restoring divide over a shared hi/lo shift pair.
module muldiv_iter #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo,
  output logic [WIDTH-1:0] cur_lo
);
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic [WIDTH:0]   add_sum, mul_hi, shifted;
  logic [WIDTH-1:0] rem_sub;
  logic             fits;

  always_comb begin
    add_sum = {1'b0, acc_hi} + {1'b0, opnd};
    mul_hi  = acc_lo[0] ? add_sum : {1'b0, acc_hi};
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    // the true difference is always below 2^WIDTH when it is taken, so modular subtraction is exact
    rem_sub = shifted[WIDTH-1:0] - opnd;
    fits    = (shifted >= {1'b0, opnd});
    if (is_div) begin
      nxt_hi = fits ? rem_sub : shifted[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], fits};
    end else begin
      nxt_hi = mul_hi[WIDTH:1];
      nxt_lo = {mul_hi[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
    end else if (load) begin
      acc_hi <= '0;
      acc_lo <= a_in;
      opnd   <= b_in;
    end else if (step) begin
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
    end
  end

  assign cur_lo = acc_lo;
endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide controller: FSM, iteration counter, sign handling, hazard stall.
// Signed operation support is built only when MULDIV_SIGNED_EN is defined.
//
// state | meaning
// IDLE  | no operation; startE accepted
// RUN   | one iteration per cycle, counter 0..31 (single cycle for divide-by-zero)
// DONE  | hi/lo valid, hlwrite strobe; startE accepted for back-to-back
module muldiv_sequencer
  import muldiv_pkg::*;
#(parameter int WIDTH = 32) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave md
);
  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic             is_div, dz, hlw_q, divzero_q;
  logic [WIDTH-1:0] hi_q, lo_q, a_load, b_load;
  logic [WIDTH-1:0] it_hi, it_lo, it_cur_lo, res_hi, res_lo;
  logic             accept, dz_in, step;

  assign accept = md.startE & ~md.cancel & (state != RUN);
  assign dz_in  = md.opE[OP_DIV_BIT] & (md.srcbE == '0);
  assign step   = (state == RUN) & ~dz;

`ifdef MULDIV_SIGNED_EN
  logic a_neg, b_neg, neg_res, neg_rem;

  assign a_neg = md.opE[OP_SGN_BIT] & md.srcaE[WIDTH-1];
  assign b_neg = md.opE[OP_SGN_BIT] & md.srcbE[WIDTH-1];
  // divide-by-zero reports the raw dividend, so keep it unconverted
  assign a_load = (a_neg & ~dz_in) ? -md.srcaE : md.srcaE;
  assign b_load = b_neg ? -md.srcbE : md.srcbE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else if (accept) begin
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
    end
  end

  always_comb begin
    res_hi = it_hi;
    res_lo = it_lo;
    if (is_div) begin
      if (neg_res) res_lo = -it_lo;
      if (neg_rem) res_hi = -it_hi;
    end else if (neg_res) begin
      {res_hi, res_lo} = -{it_hi, it_lo};
    end
  end
`else
  logic unused_sign;

  assign unused_sign = md.opE[OP_SGN_BIT];
  assign a_load = md.srcaE;
  assign b_load = md.srcbE;
  assign res_hi = it_hi;
  assign res_lo = it_lo;
`endif

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .step   (step),
    .is_div (is_div),
    .a_in   (a_load),
    .b_in   (b_load),
    .nxt_hi (it_hi),
    .nxt_lo (it_lo),
    .cur_lo (it_cur_lo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      is_div    <= 1'b0;
      dz        <= 1'b0;
      hlw_q     <= 1'b0;
      divzero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      hlw_q <= 1'b0;
      case (state)
        RUN: begin
          if (md.cancel) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (dz) begin
            state     <= DONE;
            hlw_q     <= 1'b1;
            hi_q      <= it_cur_lo;
            lo_q      <= DIVZERO_LO;
            divzero_q <= 1'b1;
            cnt       <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= DONE;
            hlw_q     <= 1'b1;
            hi_q      <= res_hi;
            lo_q      <= res_lo;
            divzero_q <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (accept) begin
            state  <= RUN;
            cnt    <= '0;
            is_div <= md.opE[OP_DIV_BIT];
            dz     <= dz_in;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign md.busy    = (state != IDLE);
  assign md.stallmd = (state != IDLE) & (md.mdreqD | md.hlreadD);
  // a flush landing on the DONE cycle must not commit hi/lo
  assign md.hlwrite = hlw_q & ~md.cancel;
  assign md.hi      = hi_q;
  assign md.lo      = lo_q;
  assign md.divzero = divzero_q;
endmodule
